// File: rtl/cym_gate_ctrl.sv
// cym_gate_ctrl: measurement gate sequencer (PRE/GATE/POST/WAIT_CALC) with calc-done toggle handshake.
// Define CYM_TIMEOUT_EN to add a TO_CYC-cycle timeout on WAIT_CALC.
module cym_gate_ctrl #(
   parameter int GATE_W   = 16,
   parameter int DEF_GATE = 2000,
   parameter int PRE_CYC  = 10,
   parameter int POST_CYC = 10,
   parameter int TO_CYC   = 65535
) (
   input  logic              clk_fx,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              cont_en,
   input  logic [GATE_W-1:0] gate_len,
   input  logic              calc_tgl,
   output logic              gate,
   output logic              gate_fall,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [15:0]       meas_cnt
);
   typedef enum logic [2:0] {IDLE, PRE, GATE, POST, WAIT_CALC} state_t;
   state_t state, state_nxt;
   logic [GATE_W-1:0] cnt, cnt_nxt, len, len_nxt;
   logic [2:0] sync;
   logic calc_evt, to_hit, done_nxt, to_nxt;

   // sync[1:0] is the 2-FF synchronizer, sync[2] the edge-detect delay
   always_ff @(posedge clk_fx or negedge rst_n)
      if (!rst_n) sync <= '0;
      else sync <= {sync[1:0], calc_tgl};
   assign calc_evt = sync[2] ^ sync[1];

`ifdef CYM_TIMEOUT_EN
   logic [15:0] to_cnt;
   always_ff @(posedge clk_fx or negedge rst_n)
      if (!rst_n) to_cnt <= '0;
      else to_cnt <= (state == WAIT_CALC && state_nxt == WAIT_CALC) ? to_cnt + 16'd1 : '0;
   assign to_hit = to_cnt == 16'(TO_CYC - 1);
`else
   logic unused_to;
   assign unused_to = ^TO_CYC;
   assign to_hit = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt + GATE_W'(1);
      len_nxt = len;
      done_nxt = 1'b0;
      to_nxt = 1'b0;
      unique case (state)
         IDLE: if (start) begin
            state_nxt = PRE;
            cnt_nxt = '0;
            len_nxt = gate_len == '0 ? GATE_W'(DEF_GATE) : gate_len;
         end
         PRE: if (cnt == GATE_W'(PRE_CYC - 1)) begin
            state_nxt = GATE;
            cnt_nxt = '0;
         end
         GATE: if (cnt == len - GATE_W'(1)) begin
            state_nxt = POST;
            cnt_nxt = '0;
         end
         POST: if (cnt == GATE_W'(POST_CYC - 1)) begin
            state_nxt = WAIT_CALC;
            cnt_nxt = '0;
         end
         WAIT_CALC: if (calc_evt || to_hit) begin
            done_nxt = calc_evt;
            to_nxt = !calc_evt;
            state_nxt = cont_en ? PRE : IDLE;
            cnt_nxt = '0;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort) begin
         state_nxt = IDLE;
         done_nxt = 1'b0;
         to_nxt = 1'b0;
      end
   end

   // outputs are registered from the next state so gate mirrors the state register exactly
   always_ff @(posedge clk_fx or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         len <= '0;
         gate <= 1'b0;
         gate_fall <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         timeout <= 1'b0;
         meas_cnt <= '0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         len <= len_nxt;
         gate <= state_nxt == GATE;
         gate_fall <= state == GATE && state_nxt == POST;
         busy <= state_nxt != IDLE;
         done <= done_nxt;
         timeout <= to_nxt;
         meas_cnt <= meas_cnt + {15'd0, done_nxt};
      end
endmodule

// File: tb/tb_cym_gate_ctrl.sv
// tb_cym_gate_ctrl: randomized bench for cym_gate_ctrl; expected event cycles are derived
// from the start/toggle stimulus times using the documented PRE/GATE/POST/sync latencies.
module tb_cym_gate_ctrl;
   logic clk_fx = 0, rst_n = 0, start = 0, abort = 0, cont_en = 0, calc_tgl = 0;
   logic [15:0] gate_len = 0;
   logic gate, gate_fall, busy, done, timeout;
   logic [15:0] meas_cnt;
   int cyc = 0, n_chk = 0, n_err = 0, mc = 0;
   int rise_q[$], fall_q[$], gf_q[$], done_q[$], to_q[$];
   int e_rise[$], e_fall[$], e_done[$], e_to[$];
   logic gate_q = 0;

   cym_gate_ctrl #(.TO_CYC(200)) dut (
      .clk_fx(clk_fx), .rst_n(rst_n), .start(start), .abort(abort), .cont_en(cont_en),
      .gate_len(gate_len), .calc_tgl(calc_tgl), .gate(gate), .gate_fall(gate_fall),
      .busy(busy), .done(done), .timeout(timeout), .meas_cnt(meas_cnt)
   );

   always #5 clk_fx = ~clk_fx;
   always @(posedge clk_fx) cyc <= cyc + 1;

   always @(negedge clk_fx) begin
      if (gate && !gate_q) rise_q.push_back(cyc);
      if (!gate && gate_q) fall_q.push_back(cyc);
      if (gate_fall) gf_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
      if (timeout) to_q.push_back(cyc);
      gate_q = gate;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_fx);
      #1;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) tick();
   endtask

   task automatic clr();
      rise_q.delete(); fall_q.delete(); gf_q.delete(); done_q.delete(); to_q.delete();
      e_rise.delete(); e_fall.delete(); e_done.delete(); e_to.delete();
   endtask

   task automatic cmp_q(input string tag, input int q[$], input int e[$]);
      chk({tag, "_count"}, q.size(), e.size());
      for (int i = 0; i < e.size() && i < q.size(); i++) chk(tag, q[i], e[i]);
   endtask

   task automatic cmp_all();
      cmp_q("rise", rise_q, e_rise);
      cmp_q("fall", fall_q, e_fall);
      cmp_q("gate_fall", gf_q, e_fall);
      cmp_q("done", done_q, e_done);
      cmp_q("timeout", to_q, e_to);
      chk("meas_cnt", int'(meas_cnt), mc & 16'hffff);
   endtask

   // Measurement from accept cycle s: gate high s+11..s+10+L, first low/gate_fall at s+11+L,
   // WAIT_CALC from s+21+L; a toggle at cycle t gives done at t+3 and, if rearmed, next s = t+2.
   task automatic run(input int glen, input bit cont, input int nm, input int dly,
                      input int chg, input bit early, input bit poke);
      int len, s, t, d;
      len = glen == 0 ? 2000 : glen;
      clr();
      gate_len = 16'(glen);
      cont_en = cont;
      s = cyc;
      start = 1;
      tick();
      start = 0;
      if (chg != 0) gate_len = 16'(chg);
      for (int k = 0; k < nm; k++) begin
         e_rise.push_back(s + 11);
         e_fall.push_back(s + 11 + len);
         if (poke) begin
            wait_to(s + 11);
            start = 1;
            tick();
            start = 0;
         end
         if (early) begin
            wait_to(s + 12 + $urandom_range(0, len));
            calc_tgl = ~calc_tgl;
         end
         d = dly < 0 ? $urandom_range(8, 30) : dly;
         t = s + 11 + len + d;
         wait_to(t);
         if (k == nm - 1) cont_en = 0;
         calc_tgl = ~calc_tgl;
         e_done.push_back(t + 3);
         mc++;
         s = t + 2;
      end
      wait_to(t + 5);
      chk("busy_end", busy, 0);
      cmp_all();
   endtask

   initial begin
      int s;
      tick();
      tick();
      chk("rst_gate", gate, 0);
      chk("rst_gate_fall", gate_fall, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_meas_cnt", int'(meas_cnt), 0);
      rst_n = 1;
      tick();
      tick();
      chk("idle_busy", busy, 0);

      run(2000, 0, 1, 50, 0, 0, 0);
      run(0, 0, 1, -1, 0, 0, 0);
      run(1, 0, 1, -1, 0, 0, 0);
      run(100, 1, 5, -1, 50, 0, 0);
      run(37, 0, 1, -1, 0, 1, 1);

      // abort in the 40th gate-high cycle
      clr();
      s = cyc;
      gate_len = 16'd100;
      start = 1;
      tick();
      start = 0;
      wait_to(s + 50);
      chk("abort_pre_gate", gate, 1);
      abort = 1;
      tick();
      abort = 0;
      chk("abort_gate", gate, 0);
      chk("abort_busy", busy, 0);
      tick();
      chk("abort_gate_fall", gf_q.size(), 0);
      chk("abort_done", done_q.size(), 0);
      chk("abort_meas_cnt", int'(meas_cnt), mc & 16'hffff);
      run(25, 0, 1, -1, 0, 0, 0);

      // start and abort together
      clr();
      start = 1;
      abort = 1;
      tick();
      start = 0;
      abort = 0;
      chk("start_abort_busy", busy, 0);
      repeat (15) tick();
      chk("start_abort_rise", rise_q.size(), 0);

      for (int i = 0; i < 8; i++) begin
         bit c;
         c = 1'($urandom_range(0, 1));
         run($urandom_range(1, 80), c, c ? $urandom_range(2, 3) : 1, -1,
             $urandom_range(0, 1) ? $urandom_range(1, 90) : 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // calc_tgl held static in WAIT_CALC
      clr();
      s = cyc;
      gate_len = 16'd20;
      start = 1;
      tick();
      start = 0;
      e_rise.push_back(s + 11);
      e_fall.push_back(s + 31);
`ifdef CYM_TIMEOUT_EN
      e_to.push_back(s + 41 + 200);
      wait_to(s + 41 + 205);
      chk("to_busy", busy, 0);
      cmp_all();
`else
      wait_to(s + 41 + 10000);
      chk("wait_busy", busy, 1);
      cmp_all();
      abort = 1;
      tick();
      abort = 0;
      tick();
      chk("wait_abort_busy", busy, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/cym_gate_ctrl.md
Name: cym_gate_ctrl

Overview:
- Gate-sequencing controller for the equal-precision frequency counter, clocked by the measured clock clk_fx.
- Generates the measurement gate with run-time gate length, fixed pre/post guard intervals and a start/busy/done handshake.
- Waits for the reference-domain divide to finish (toggle handshake) before arming the next gate, so a result is never overwritten mid-calculation.
- Supports single-shot and continuous modes.

Parameters:
- GATE_W, 16, width of gate length and gate counter.
- DEF_GATE, 2000, gate length used when gate_len==0.
- PRE_CYC, 10, gate-low clk_fx cycles before gate rises.
- POST_CYC, 10, gate-low clk_fx cycles after gate falls.
- TO_CYC, 65535, WAIT_CALC timeout in clk_fx cycles (optional feature only).

Ports:
- clk_fx, input, 1, measured clock; all logic on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to begin a measurement.
- abort, input, 1, level; forces return to IDLE.
- cont_en, input, 1, 1 = rearm automatically after each completed measurement.
- gate_len, input, GATE_W, gate high time in clk_fx cycles; sampled at accept.
- calc_tgl, input, 1, toggles once per finished divide; asynchronous (reference domain).
- gate, output, 1, registered gate to the counter datapath.
- gate_fall, output, 1, one-cycle pulse on the first cycle gate is low after the GATE state.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when a measurement completes.
- timeout, output, 1, one-cycle pulse on WAIT_CALC timeout.
- meas_cnt, output, 16, completed-measurement count; wraps 65535->0.

Behaviour:
- Reset values: gate=0, gate_fall=0, busy=0, done=0, timeout=0, meas_cnt=0, FSM in IDLE.
- calc_tgl passes through a 2-FF synchronizer plus one delay register. calc_evt = XOR of the last two synchronized stages.
- FSM states:
  - IDLE: start && !abort latches len = (gate_len==0 ? DEF_GATE : gate_len), clears the counter, goes to PRE. start in any other state is ignored.
  - PRE: gate=0 for exactly PRE_CYC cycles, then GATE.
  - GATE: gate=1 for exactly len cycles. The first gate-high cycle is the cycle after PRE ends. Then POST.
  - POST: gate=0, gate_fall=1 on the first POST cycle only. Lasts POST_CYC cycles, then WAIT_CALC.
  - WAIT_CALC: gate=0, waiting for calc_evt. A calc_evt seen in any other state is discarded.
    - On calc_evt: pulse done, meas_cnt+1, then PRE if cont_en==1, else IDLE.
    - cont_en is sampled at this transition only.
- gate is a pure function of the registered state. No glitch and no combinational path from inputs to gate.
- abort (highest priority, any state): next cycle state=IDLE, gate=0, busy=0, no done, meas_cnt unchanged.
  - If abort falls during GATE, gate_fall is NOT pulsed.
  - abort and start asserted together: abort wins; stay in IDLE.
- Changing gate_len while busy has no effect until the next accept from IDLE. Continuous rearm reuses the latched len.
- Counter width: GATE_W bits. len = 2^GATE_W-1 is legal.

Optional Feature:
- Macro CYM_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in WAIT_CALC.
  - After TO_CYC cycles with no calc_evt: pulse timeout, no done, meas_cnt unchanged.
  - Then go to PRE if cont_en, else IDLE.
  - If calc_evt and timeout fall on the same cycle, calc_evt wins.
- Not defined: no counter is instantiated, WAIT_CALC waits indefinitely, and timeout is tied to 0.

Test Plan:
- Reset, then start with gate_len=2000, cont_en=0, PRE/POST=10, then toggle calc_tgl 50 cycles after gate_fall.
  - gate rises 11 cycles after start and stays high exactly 2000 cycles.
  - gate_fall pulses once.
  - done pulses 3 cycles after the calc_evt source edge.
  - meas_cnt=1 and busy=0.
- gate_len=0 -> gate high exactly 2000 (DEF_GATE) cycles. gate_len=1 -> gate high exactly 1 cycle.
- cont_en=1, gate_len=100, calc_tgl toggled after each gate_fall, run 5 measurements.
  - 5 done pulses and meas_cnt=5.
  - PRE follows done with no IDLE cycle.
  - Changing gate_len to 50 mid-run has no effect.
- abort at GATE cycle 40.
  - Next cycle gate=0, busy=0, no gate_fall, no done.
  - A start 1 cycle later is accepted normally.
- start+abort in the same cycle -> stays IDLE. start while busy -> ignored (gate count unchanged). calc_tgl toggle during GATE -> discarded; done only after a second toggle in WAIT_CALC.
- With CYM_TIMEOUT_EN and TO_CYC=200, calc_tgl held static:
  - timeout pulses 200 cycles into WAIT_CALC, no done, meas_cnt=0, FSM returns to IDLE.
  - Without the macro: FSM stays in WAIT_CALC for 10000 cycles and timeout stays 0.
